tlb: RTL and testbench
======================

# tlb

Fully-associative translation lookaside buffer that sits directly upstream of the page table walker. It accepts 32-bit virtual-address translation requests from the core side and returns physical addresses from its entry array on a hit. On a miss it issues one walk request to `ptw`, fills an entry from the returned leaf PTE, and answers the original request. All interfaces use valid/ready handshakes.

## Interface
- `ENTRIES`, default 4: number of entries; a power of two, minimum 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: one clock; reset is synchronous and active-high.
- `tlb_req_valid_i`  in  1: translation request valid.
- `tlb_req_ready_o`  out  1: request accepted on the edge where valid & ready.
- `tlb_vaddr_i`  in  32: virtual address.
- `tlb_acc_i`  in  2: access type; 00 load, 01 store, 10 fetch, 11 reserved.
- `tlb_resp_valid_o`  out  1: response valid.
- `tlb_resp_ready_i`  in  1: response consumer ready.
- `tlb_paddr_o`  out  32: physical address, equal to {PPN, vaddr[11:0]}; 0 on fault.
- `tlb_hit_o`  out  1: served from the array without a walk.
- `tlb_fault_o`  out  1: translation fault.
- `flush_i`  in  1: invalidate all entries.
- `ptw_req_valid_o`  out  1: walk request valid.
- `ptw_req_ready_i`  in  1: walker ready.
- `ptw_vaddr_o`  out  32: address to walk, equal to the latched request vaddr.
- `ptw_resp_valid_i`  in  1: walk result valid.
- `ptw_resp_ready_o`  out  1: TLB ready for the walk result.
- `ptw_pte_i`  in  32: leaf PTE. PPN is [31:12]. Flag bits: V=[0], R=[1], W=[2], X=[3]. 0 means invalid.

## Operation
- Entry fields: valid, VPN[31:12], PPN[31:12], flags[3:0].
- FSM states and transitions:
  - IDLE: `tlb_req_ready_o`=1. On handshake, latch vaddr and acc, then go to LOOKUP.
  - LOOKUP: compare latched VPN against all valid entries (at most one match).
    - Hit: go to RESP with hit=1.
    - Miss: go to PTW_REQ.
  - PTW_REQ: `ptw_req_valid_o`=1. On `ptw_req_ready_i`, go to PTW_WAIT.
  - PTW_WAIT: `ptw_resp_ready_o`=1. On `ptw_resp_valid_i`:
    - If PTE V=1, fill an entry.
    - If PTE V=0, set fault, paddr=0, and do not fill.
    - Then go to RESP with hit=0.
  - RESP: `tlb_resp_valid_o`=1 and response outputs held stable. On `tlb_resp_ready_i`, go to IDLE.
- Victim selection:
  - Lowest-index invalid entry if one exists.
  - Otherwise the round-robin pointer, log2(ENTRIES) bits. The pointer increments, wrapping ENTRIES-1 to 0, only when it supplies the victim.
- Flush:
  - `flush_i` clears all valid bits at the edge it is sampled. It is legal in any state.
  - Flush in the same edge as a request handshake: the lookup sees an empty array.
  - Flush sampled while in PTW_REQ or PTW_WAIT: the walk completes and is answered, but the fill is suppressed. A pending-flush flag is set and cleared on return to IDLE.
  - The round-robin pointer is not reset by flush.
- Reset clears all entries, the pointer and the FSM. Reset mid-walk abandons the transaction; the bench re-resets `ptw` alongside.

## Timing
- Reset values:
  - `tlb_req_ready_o`=1.
  - All other outputs 0.
- Hit latency: `tlb_resp_valid_o` rises 2 cycles after request acceptance.
- Miss latency: 2 cycles plus the walk time. `ptw_req_valid_o` rises 2 cycles after acceptance. `tlb_resp_valid_o` rises 1 cycle after the PTW response handshake.
- At most one translation in flight. `tlb_req_ready_o`=0 in every state except IDLE.
- Once asserted, `ptw_req_valid_o` and `tlb_resp_valid_o` stay high with stable data until their handshake.
- A filled entry is visible to the next LOOKUP.

## Configuration
- `TLB_PERM_CHECK_EN` defined:
  - A fault is raised if the required flag is clear: load needs R, store needs W, fetch needs X; acc=11 always faults.
  - The check applies to hits and fills alike.
  - A permission fault on a hit returns hit=1, fault=1, paddr=0; the entry is retained.
  - A V=1 PTE that fails the permission check is still filled.
- Undefined: only V is checked and `tlb_acc_i` is ignored.

## Test plan
- Reset:
  - After reset → `tlb_req_ready_o`=1.
  - `tlb_resp_valid_o`=`ptw_req_valid_o`=`ptw_resp_ready_o`=0.
- Cold miss then hit:
  - Load 0x00000ABC, PTW model returns 0x1000000F → exactly one walk with `ptw_vaddr_o`=0x00000ABC; response paddr=0x10000ABC, hit=0, fault=0.
  - Then 0x00000123 → paddr=0x10000123, hit=1, response 2 cycles after accept, no walk.
- Invalid PTE:
  - 0x00400000 with PTE 0x00000000 → fault=1, paddr=0, hit=0.
  - Repeat the request → a second walk is issued (no fill occurred).
- Replacement with ENTRIES=4:
  - Fill VPNs 0,1,2,3, then VPN 4 → VPN 0 is evicted and the pointer moves to 1.
  - Access VPN 0 → miss and walk; VPN 1 is evicted.
- Flush:
  - `flush_i` pulsed during PTW_WAIT for 0x00001000 (PTE 0x1100000F) → response paddr=0x11000000.
  - Re-access 0x00001000 → miss (no fill occurred).
  - Flush in the same cycle as a request for a cached page → miss.
- Permissions (with `TLB_PERM_CHECK_EN`), PTE 0x12000007:
  - Store to 0x00002000 → paddr=0x12000000, fault=0.
  - Fetch to 0x00002000 → hit=1, fault=1, paddr=0.

Source files
------------

// File: rtl/tlb_if.sv
// Valid/ready bundle for the TLB: core request/response, flush, and the walker side.
// The slave modport is the TLB's view; master is the environment's view.
interface tlb_if;
  logic        tlb_req_valid_i;
  logic        tlb_req_ready_o;
  logic [31:0] tlb_vaddr_i;
  logic [1:0]  tlb_acc_i;
  logic        tlb_resp_valid_o;
  logic        tlb_resp_ready_i;
  logic [31:0] tlb_paddr_o;
  logic        tlb_hit_o;
  logic        tlb_fault_o;
  logic        flush_i;
  logic        ptw_req_valid_o;
  logic        ptw_req_ready_i;
  logic [31:0] ptw_vaddr_o;
  logic        ptw_resp_valid_i;
  logic        ptw_resp_ready_o;
  logic [31:0] ptw_pte_i;

  modport slave (
    input  tlb_req_valid_i, tlb_vaddr_i, tlb_acc_i, tlb_resp_ready_i, flush_i,
           ptw_req_ready_i, ptw_resp_valid_i, ptw_pte_i,
    output tlb_req_ready_o, tlb_resp_valid_o, tlb_paddr_o, tlb_hit_o, tlb_fault_o,
           ptw_req_valid_o, ptw_vaddr_o, ptw_resp_ready_o
  );

  modport master (
    output tlb_req_valid_i, tlb_vaddr_i, tlb_acc_i, tlb_resp_ready_i, flush_i,
           ptw_req_ready_i, ptw_resp_valid_i, ptw_pte_i,
    input  tlb_req_ready_o, tlb_resp_valid_o, tlb_paddr_o, tlb_hit_o, tlb_fault_o,
           ptw_req_valid_o, ptw_vaddr_o, ptw_resp_ready_o
  );
endinterface

// File: rtl/tlb.sv
// Fully-associative TLB in front of the page table walker, one translation in flight.
// Define TLB_PERM_CHECK_EN to enable R/W/X permission faults keyed by access type.
//
// state      | meaning
// S_IDLE     | ready for a request; latches vaddr (and access type)
// S_LOOKUP   | compare latched VPN against all valid entries
// S_PTW_REQ  | walk request presented to the walker
// S_PTW_WAIT | waiting for the leaf PTE; fill on V=1 unless a flush intervened
// S_RESP     | response held stable until the consumer takes it
module tlb #(
  parameter int ENTRIES = 4
) (
  input logic clk,
  input logic rst,
  tlb_if.slave bus
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_PTW_REQ,
    S_PTW_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [ENTRIES-1:0] ent_valid_q;
  logic [19:0]        ent_vpn_q [ENTRIES];
  logic [19:0]        ent_ppn_q [ENTRIES];
  logic [IDX_W-1:0]   rr_q;
  logic [31:0]        vaddr_q;
  logic               flush_pend_q;
  logic [31:0]        paddr_q;
  logic               hit_q;
  logic               fault_q;

  logic               lk_hit;
  logic [19:0]        lk_ppn;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   victim;
  logic               fill_en;
  logic               hit_pf;
  logic               fill_pf;

`ifdef TLB_PERM_CHECK_EN
  logic [1:0] acc_q;
  logic [3:1] ent_flags_q [ENTRIES];
  logic [3:1] lk_flags;

  function automatic logic perm_fail(input logic [1:0] acc, input logic [3:1] flags);
    case (acc)
      2'b00:   perm_fail = !flags[1];
      2'b01:   perm_fail = !flags[2];
      2'b10:   perm_fail = !flags[3];
      default: perm_fail = 1'b1;
    endcase
  endfunction

  always_comb begin
    lk_flags = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_valid_q[i] && ent_vpn_q[i] == vaddr_q[31:12]) lk_flags = lk_flags | ent_flags_q[i];
    end
  end

  assign hit_pf  = perm_fail(acc_q, lk_flags);
  assign fill_pf = perm_fail(acc_q, bus.ptw_pte_i[3:1]);

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else if (state_q == S_IDLE && bus.tlb_req_valid_i) acc_q <= bus.tlb_acc_i;
  end

  always_ff @(posedge clk) begin
    if (fill_en) ent_flags_q[victim] <= bus.ptw_pte_i[3:1];
  end
`else
  assign hit_pf  = 1'b0;
  assign fill_pf = 1'b0;
`endif

  // At most one entry matches, so OR-combining the matching PPNs is exact.
  always_comb begin
    lk_hit = 1'b0;
    lk_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_valid_q[i] && ent_vpn_q[i] == vaddr_q[31:12]) begin
        lk_hit = 1'b1;
        lk_ppn = lk_ppn | ent_ppn_q[i];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!ent_valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign victim  = free_found ? free_idx : rr_q;
  assign fill_en = (state_q == S_PTW_WAIT) && bus.ptw_resp_valid_i && bus.ptw_pte_i[0]
                   && !flush_pend_q && !bus.flush_i;

  always_comb begin
    state_d              = state_q;
    bus.tlb_req_ready_o  = 1'b0;
    bus.ptw_req_valid_o  = 1'b0;
    bus.ptw_resp_ready_o = 1'b0;
    bus.tlb_resp_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.tlb_req_ready_o = 1'b1;
        if (bus.tlb_req_valid_i) state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = lk_hit ? S_RESP : S_PTW_REQ;
      S_PTW_REQ: begin
        bus.ptw_req_valid_o = 1'b1;
        if (bus.ptw_req_ready_i) state_d = S_PTW_WAIT;
      end
      S_PTW_WAIT: begin
        bus.ptw_resp_ready_o = 1'b1;
        if (bus.ptw_resp_valid_i) state_d = S_RESP;
      end
      S_RESP: begin
        bus.tlb_resp_valid_o = 1'b1;
        if (bus.tlb_resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.tlb_paddr_o = paddr_q;
  assign bus.tlb_hit_o   = hit_q;
  assign bus.tlb_fault_o = fault_q;
  assign bus.ptw_vaddr_o = (state_q == S_PTW_REQ) ? vaddr_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ent_valid_q  <= '0;
      rr_q         <= '0;
      vaddr_q      <= '0;
      flush_pend_q <= 1'b0;
      paddr_q      <= '0;
      hit_q        <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (bus.tlb_req_valid_i) vaddr_q <= bus.tlb_vaddr_i;
        S_LOOKUP: if (lk_hit) begin
          hit_q   <= 1'b1;
          fault_q <= hit_pf;
          paddr_q <= hit_pf ? 32'h0 : {lk_ppn, vaddr_q[11:0]};
        end
        S_PTW_WAIT: if (bus.ptw_resp_valid_i) begin
          hit_q <= 1'b0;
          if (bus.ptw_pte_i[0]) begin
            fault_q <= fill_pf;
            paddr_q <= fill_pf ? 32'h0 : {bus.ptw_pte_i[31:12], vaddr_q[11:0]};
          end else begin
            fault_q <= 1'b1;
            paddr_q <= '0;
          end
          if (fill_en) begin
            ent_valid_q[victim] <= 1'b1;
            if (!free_found) rr_q <= rr_q + 1'b1;
          end
        end
        S_RESP: if (bus.tlb_resp_ready_i) begin
          hit_q        <= 1'b0;
          fault_q      <= 1'b0;
          paddr_q      <= '0;
          flush_pend_q <= 1'b0;
        end
        default: ;
      endcase
      // Flush wins over any fill on the same edge; a flush during the walk also blocks its fill.
      if (bus.flush_i) begin
        ent_valid_q <= '0;
        if (state_q == S_PTW_REQ || state_q == S_PTW_WAIT) flush_pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      ent_vpn_q[victim] <= vaddr_q[31:12];
      ent_ppn_q[victim] <= bus.ptw_pte_i[31:12];
    end
  end
endmodule

// File: tb/tb_tlb.sv
// Self-checking bench for tlb: directed scenarios then randomized traffic against a
// behavioural entry-table model with a PTE lookup table standing in for the walker.
module tb_tlb;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  tlb_if bus ();

  tlb #(.ENTRIES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  bit          m_valid [N];
  logic [19:0] m_vpn   [N];
  logic [19:0] m_ppn   [N];
  logic [3:0]  m_flags [N];
  int          m_rr;
  logic [31:0] pte_mem [int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
  endtask

  function automatic int model_find(input logic [19:0] vpn);
    for (int i = 0; i < N; i++) if (m_valid[i] && m_vpn[i] == vpn) return i;
    return -1;
  endfunction

  function automatic logic model_perm_fault(input logic [1:0] acc, input logic [3:0] flags);
`ifdef TLB_PERM_CHECK_EN
    if (acc == 2'd0) return !flags[1];
    if (acc == 2'd1) return !flags[2];
    if (acc == 2'd2) return !flags[3];
    return 1'b1;
`else
    return (acc == 2'd3) && (flags == 4'hF) && 1'b0;
`endif
  endfunction

  task automatic model_fill(input logic [19:0] vpn, input logic [31:0] pte);
    int v = -1;
    for (int i = 0; i < N; i++) if (!m_valid[i] && v < 0) v = i;
    if (v < 0) begin
      v    = m_rr;
      m_rr = (m_rr + 1) % N;
    end
    m_valid[v] = 1'b1;
    m_vpn[v]   = vpn;
    m_ppn[v]   = pte[31:12];
    m_flags[v] = pte[3:0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.tlb_req_valid_i  = 1'b0;
    bus.tlb_vaddr_i      = '0;
    bus.tlb_acc_i        = '0;
    bus.tlb_resp_ready_i = 1'b0;
    bus.flush_i          = 1'b0;
    bus.ptw_req_ready_i  = 1'b0;
    bus.ptw_resp_valid_i = 1'b0;
    bus.ptw_pte_i        = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_flush();
    m_rr = 0;
  endtask

  // fl_mode: 0 none, 1 flush on the accept edge, 2 flush while the walk is outstanding
  task automatic xact(input logic [31:0] va, input logic [1:0] acc, input int fl_mode);
    int          idx;
    int          cyc;
    bit          exp_hit;
    logic        exp_fault;
    logic [31:0] exp_pa;
    logic [31:0] pte;
    pte = pte_mem.exists(int'(va[31:12])) ? pte_mem[int'(va[31:12])] : 32'h0;
    check("req_ready_idle", bus.tlb_req_ready_o, 1);
    if (fl_mode == 1) model_flush();
    idx     = model_find(va[31:12]);
    exp_hit = (idx >= 0);
    if (exp_hit) begin
      exp_fault = model_perm_fault(acc, m_flags[idx]);
      exp_pa    = exp_fault ? 32'h0 : {m_ppn[idx], va[11:0]};
    end else if (pte[0]) begin
      exp_fault = model_perm_fault(acc, pte[3:0]);
      exp_pa    = exp_fault ? 32'h0 : {pte[31:12], va[11:0]};
    end else begin
      exp_fault = 1'b1;
      exp_pa    = 32'h0;
    end

    bus.tlb_req_valid_i = 1'b1;
    bus.tlb_vaddr_i     = va;
    bus.tlb_acc_i       = acc;
    bus.flush_i         = (fl_mode == 1);
    @(posedge clk);
    #1;
    bus.tlb_req_valid_i = 1'b0;
    bus.flush_i         = 1'b0;
    bus.tlb_vaddr_i     = $urandom;
    bus.tlb_acc_i       = 2'($urandom);
    check("req_ready_busy", bus.tlb_req_ready_o, 0);

    cyc = 1;
    while (!(bus.ptw_req_valid_o || bus.tlb_resp_valid_o) && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("first_out_latency", cyc, 2);
    check("walk_issued", bus.ptw_req_valid_o, !exp_hit);

    if (bus.ptw_req_valid_o) begin
      check("ptw_vaddr", bus.ptw_vaddr_o, va);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1 check("ptw_req_hold", {bus.ptw_req_valid_o, bus.ptw_vaddr_o}, {1'b1, va});
      end
      bus.ptw_req_ready_i = 1'b1;
      @(posedge clk);
      #1 bus.ptw_req_ready_i = 1'b0;
      check("ptw_req_dropped", bus.ptw_req_valid_o, 0);
      if (fl_mode == 2) begin
        bus.flush_i = 1'b1;
        model_flush();
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 check("ptw_resp_ready", bus.ptw_resp_ready_o, 1);
      bus.ptw_resp_valid_i = 1'b1;
      bus.ptw_pte_i        = pte;
      @(posedge clk);
      #1;
      bus.ptw_resp_valid_i = 1'b0;
      bus.ptw_pte_i        = $urandom;
      check("resp_after_walk", bus.tlb_resp_valid_o, 1);
    end
    if (!exp_hit && pte[0] && fl_mode != 2) model_fill(va[31:12], pte);

    check("resp_valid", bus.tlb_resp_valid_o, 1);
    check("paddr", bus.tlb_paddr_o, exp_pa);
    check("hit", bus.tlb_hit_o, exp_hit);
    check("fault", bus.tlb_fault_o, exp_fault);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1 check("resp_hold", {bus.tlb_resp_valid_o, bus.tlb_paddr_o, bus.tlb_hit_o, bus.tlb_fault_o},
                            {1'b1, exp_pa, exp_hit, exp_fault});
    end
    bus.tlb_resp_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.tlb_resp_ready_i = 1'b0;
    check("resp_done", {bus.tlb_resp_valid_o, bus.tlb_req_ready_o}, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_req_ready", bus.tlb_req_ready_o, 1);
    check("rst_resp_valid", bus.tlb_resp_valid_o, 0);
    check("rst_ptw_req_valid", bus.ptw_req_valid_o, 0);
    check("rst_ptw_resp_ready", bus.ptw_resp_ready_o, 0);
    check("rst_outputs", {bus.tlb_paddr_o, bus.tlb_hit_o, bus.tlb_fault_o}, 0);

    // cold miss then hit on the same page
    pte_mem[0] = 32'h1000_000F;
    xact(32'h0000_0ABC, 2'd0, 0);
    xact(32'h0000_0123, 2'd0, 0);

    // invalid PTE: fault without fill, so the repeat walks again
    pte_mem[32'h400] = 32'h0;
    xact(32'h0040_0000, 2'd0, 0);
    xact(32'h0040_0000, 2'd0, 0);

    // replacement: five fills, then the evicted pages miss again
    do_reset();
    for (int v = 0; v < 5; v++) pte_mem[v] = {20'h20000 + 20'(v), 12'h00F};
    for (int v = 0; v < 5; v++) xact({20'(v), 12'h010}, 2'd0, 0);
    xact(32'h0000_0020, 2'd0, 0);
    xact(32'h0000_1030, 2'd0, 0);
    xact(32'h0000_3040, 2'd0, 0);

    // flush during walk suppresses the fill; flush with the request forces a miss
    do_reset();
    pte_mem[1] = 32'h1100_000F;
    xact(32'h0000_1000, 2'd0, 2);
    xact(32'h0000_1000, 2'd0, 0);
    xact(32'h0000_1000, 2'd0, 0);
    xact(32'h0000_1000, 2'd0, 1);

    // permission behaviour (model covers both builds)
    pte_mem[2] = 32'h1200_0007;
    xact(32'h0000_2000, 2'd1, 0);
    xact(32'h0000_2000, 2'd2, 0);
    xact(32'h0000_2000, 2'd3, 0);

    // randomized traffic over a small page pool
    do_reset();
    for (int v = 0; v < 10; v++) begin
      logic [3:0] fl;
      fl    = 4'($urandom_range(0, 15));
      fl[0] = ($urandom_range(0, 4) != 0);
      pte_mem[v] = {20'($urandom), 8'h00, fl};
    end
    for (int t = 0; t < 150; t++) begin
      int r;
      r = $urandom_range(0, 9);
      xact({20'($urandom_range(0, 9)), 12'($urandom)}, 2'($urandom_range(0, 3)),
           (r == 0) ? 1 : (r == 1) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
